// File: rtl/dma_pkg.sv
// Shared types and constants for the S2MM burst scheduler.
package dma_pkg;

    localparam int unsigned AXI_4K_BYTES = 4096;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        DONE
    } sched_state_e;

    // awsize encoding for a data bus of the given width in bits
    function automatic logic [2:0] beat_size(input int unsigned width);
        return 3'($clog2(width / 8));
    endfunction

endpackage

// File: rtl/s2mm_burst_calc.sv
// Combinational burst-size selection: min(remaining, max burst, beats to next 4KB).
// The 4KB limit is only applied when S2MM_4K_BOUNDARY_EN is defined.
module s2mm_burst_calc
    import dma_pkg::*;
#(
    parameter int unsigned BEATS_WIDTH     = 16,
    parameter int unsigned MAX_BURST_BEATS = 16,
    parameter int unsigned BEAT_LOG2       = 3
) (
    input  logic [BEATS_WIDTH-1:0] i_remaining,
    input  logic [11:0]            i_addr_lo,
    output logic [BEATS_WIDTH:0]   o_nb
);

    localparam int unsigned NB_W = BEATS_WIDTH + 1;

    logic [NB_W-1:0] w_rem;
    logic [NB_W-1:0] w_max;

    assign w_rem = {1'b0, i_remaining};
    assign w_max = NB_W'(MAX_BURST_BEATS);

`ifdef S2MM_4K_BOUNDARY_EN
    logic [12:0]     w_room_bytes;
    logic [NB_W-1:0] w_room_beats;

    // address is beat aligned, so the shift is exact
    assign w_room_bytes = 13'(AXI_4K_BYTES) - {1'b0, i_addr_lo};
    assign w_room_beats = NB_W'(w_room_bytes >> BEAT_LOG2);

    always_comb begin
        o_nb = (w_rem < w_max) ? w_rem : w_max;
        if (w_room_beats < o_nb) begin
            o_nb = w_room_beats;
        end
    end
`else
    logic w_unused_addr;
    assign w_unused_addr = ^i_addr_lo;

    always_comb begin
        o_nb = (w_rem < w_max) ? w_rem : w_max;
    end
`endif

endmodule

// File: rtl/s2mm_burst_scheduler.sv
// Splits one S2MM write command into AXI4 INCR bursts and sequences them through the write channel.
// Optional 4KB-boundary splitting is enabled with the S2MM_4K_BOUNDARY_EN macro.
module s2mm_burst_scheduler
    import dma_pkg::*;
#(
    parameter int unsigned DMA_DATA_WIDTH_SRC = 64,
    parameter int unsigned DMA_AXI_ADDR_WIDTH = 32,
    parameter int unsigned BEATS_WIDTH        = 16,
    parameter int unsigned MAX_BURST_BEATS    = 16
) (
    input  logic                          m_axi_aclk,
    input  logic                          m_axi_aresetn,
    input  logic                          s_cmd_valid,
    output logic                          s_cmd_ready,
    input  logic [DMA_AXI_ADDR_WIDTH-1:0] s_cmd_addr,
    input  logic [BEATS_WIDTH-1:0]        s_cmd_beats,
    output logic                          write_start_o,
    output logic [DMA_AXI_ADDR_WIDTH-1:0] write_addr_o,
    output logic [7:0]                    write_len_o,
    output logic [2:0]                    write_size_o,
    input  logic                          write_busy_i,
    output logic                          cmd_done_o,
    output logic                          busy_o,
    output logic [BEATS_WIDTH-1:0]        burst_cnt_o
);

    localparam int unsigned AW    = DMA_AXI_ADDR_WIDTH;
    localparam int unsigned BW    = BEATS_WIDTH;
    localparam int unsigned LOG2B = $clog2(DMA_DATA_WIDTH_SRC / 8);
    localparam logic [2:0]  SIZE  = beat_size(DMA_DATA_WIDTH_SRC);
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'((1 << LOG2B) - 1);

    sched_state_e    r_state;
    logic [AW-1:0]   r_addr;
    logic [BW-1:0]   r_rem;
    logic [BW:0]     r_nb;
    logic            r_ready;
    logic            r_start;
    logic            r_done;
    logic            r_busy;
    logic [BW-1:0]   r_cnt;
    logic [AW-1:0]   r_waddr;
    logic [7:0]      r_wlen;

    logic [BW:0]     w_nb;
    logic [AW-1:0]   w_inc;

    s2mm_burst_calc #(
        .BEATS_WIDTH    (BW),
        .MAX_BURST_BEATS(MAX_BURST_BEATS),
        .BEAT_LOG2      (LOG2B)
    ) u_calc (
        .i_remaining(r_rem),
        .i_addr_lo  (r_addr[11:0]),
        .o_nb       (w_nb)
    );

    // byte advance of the burst just finished; wraps at the address width
    assign w_inc = AW'(r_nb) << LOG2B;

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_nb    <= '0;
            r_ready <= 1'b1;
            r_start <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_waddr <= '0;
            r_wlen  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (s_cmd_valid && r_ready) begin
                        r_addr  <= s_cmd_addr & ALIGN_MASK;
                        r_rem   <= s_cmd_beats;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    if (r_rem == '0) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_nb    <= w_nb;
                        r_waddr <= r_addr;
                        r_wlen  <= 8'(w_nb - 1'b1);
                        r_start <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    r_start <= 1'b0;
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (write_busy_i) begin
                        r_state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!write_busy_i) begin
                        r_addr  <= r_addr + w_inc;
                        r_rem   <= r_rem - BW'(r_nb);
                        r_cnt   <= r_cnt + BW'(1);
                        r_state <= CALC;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_cmd_ready   = r_ready;
    assign write_start_o = r_start;
    assign write_addr_o  = r_waddr;
    assign write_len_o   = r_wlen;
    assign write_size_o  = SIZE;
    assign cmd_done_o    = r_done;
    assign busy_o        = r_busy;
    assign burst_cnt_o   = r_cnt;

endmodule
